frame_bank_rotator: RTL

FRAME_BANK_ROTATOR -- requirements
Module: frame_bank_rotator

---
 rtl/frame_bank_rotator.sv | 85 ++++++++
 1 files changed

// File: rtl/frame_bank_rotator.sv
// frame_bank_rotator: rotates reader/writer one-hot bank selects across a ring of frame buffers
module frame_bank_rotator #(
  parameter int NUM_BANKS = 2,
  parameter int PIXELS_PER_FRAME = 480000,
  parameter int IDX_W = (NUM_BANKS > 2) ? $clog2(NUM_BANKS) : 1
) (
  input  logic                 CLK_40,
  input  logic                 reset,
  input  logic                 init,
  input  logic                 pixel_en,
  input  logic                 wr_frame_done,
  output logic [NUM_BANKS-1:0] read_bank,
  output logic [NUM_BANKS-1:0] write_bank,
  output logic [IDX_W-1:0]     read_idx,
  output logic [IDX_W-1:0]     write_idx,
  output logic                 wr_ready,
  output logic                 switch_mode,
  output logic                 frame_repeat,
  output logic                 wr_overflow
);
  localparam int PIX_W = $clog2(PIXELS_PER_FRAME);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state;
  logic [IDX_W-1:0] rd_ptr, filled, rd_n, filled_n, wi_n;
  logic [PIX_W-1:0] pix_cnt, pix_n;
  logic [IDX_W:0] sum;
  logic run, boundary, adv, room, acc, ovf, rdy_n;
  always_comb begin
    run = state == RUN;
    boundary = run && pixel_en && pix_cnt == PIX_W'(PIXELS_PER_FRAME - 1);
    adv = boundary && filled != '0;
    room = filled < IDX_W'(NUM_BANKS - 1);
    acc = run && wr_frame_done && room;
    ovf = run && wr_frame_done && !room;
    pix_n = boundary ? '0 : (run && pixel_en) ? pix_cnt + PIX_W'(1) : pix_cnt;
    rd_n = !adv ? rd_ptr : rd_ptr == IDX_W'(NUM_BANKS - 1) ? '0 : rd_ptr + IDX_W'(1);
    filled_n = filled + IDX_W'(acc) - IDX_W'(adv);
    rdy_n = filled_n < IDX_W'(NUM_BANKS - 1);
    sum = (IDX_W + 1)'(rd_n) + (IDX_W + 1)'(filled_n) + (IDX_W + 1)'(1);
    wi_n = IDX_W'(sum >= (IDX_W + 1)'(NUM_BANKS) ? sum - (IDX_W + 1)'(NUM_BANKS) : sum);
  end
  always_ff @(posedge CLK_40) begin
    if (reset) begin
      state <= IDLE;
      rd_ptr <= '0;
      filled <= '0;
      pix_cnt <= '0;
      read_bank <= '0;
      write_bank <= '0;
      read_idx <= '0;
      write_idx <= '0;
      wr_ready <= 1'b0;
      switch_mode <= 1'b0;
      frame_repeat <= 1'b0;
      wr_overflow <= 1'b0;
    end else if (!run) begin
      switch_mode <= 1'b0;
      frame_repeat <= 1'b0;
      wr_overflow <= 1'b0;
      if (init) begin
        state <= RUN;
        rd_ptr <= '0;
        filled <= '0;
        pix_cnt <= '0;
        read_bank <= NUM_BANKS'(1);
        write_bank <= NUM_BANKS'(2);
        read_idx <= '0;
        write_idx <= IDX_W'(1);
        wr_ready <= 1'b1;
      end
    end else begin
      rd_ptr <= rd_n;
      filled <= filled_n;
      pix_cnt <= pix_n;
      read_idx <= rd_n;
      read_bank <= NUM_BANKS'(1) << rd_n;
      wr_ready <= rdy_n;
      write_idx <= rdy_n ? wi_n : write_idx;
      write_bank <= rdy_n ? NUM_BANKS'(1) << wi_n : '0;
      switch_mode <= adv;
      frame_repeat <= boundary && !adv;
      wr_overflow <= ovf;
    end
  end
endmodule
